phoenix_input_buffer: RTL

//  Per-port input stage of the router: one instance per port (EAST..LOCAL), directly upstream of switchcontrol.

---
 rtl/phoenix_input_buffer_pkg.sv | 23 ++
 rtl/phoenix_input_buffer_if.sv | 26 ++
 rtl/phoenix_flit_fifo.sv | 62 ++++++
 rtl/phoenix_input_buffer.sv | 102 ++++++++++
 4 files changed

// File: rtl/phoenix_input_buffer_pkg.sv
// Shared definitions for the router input buffer: sizes, port indices and FSM state codes.
package phoenix_input_buffer_pkg;

    localparam int unsigned TAM_FLIT   = 16;
    localparam int unsigned TAM_BUFFER = 16;

    // Router port indices, one input buffer instance per port
    localparam int unsigned EAST  = 0;
    localparam int unsigned WEST  = 1;
    localparam int unsigned NORTH = 2;
    localparam int unsigned SOUTH = 3;
    localparam int unsigned LOCAL = 4;

    typedef enum logic [2:0] {
        S_INIT       = 3'd0,
        S_HEADER     = 3'd1,
        S_SENDHEADER = 3'd2,
        S_SIZE       = 3'd3,
        S_PAYLOAD    = 3'd4,
        S_END        = 3'd5
    } ib_state_e;

endpackage

// File: rtl/phoenix_input_buffer_if.sv
// Link, routing-request and crossbar handshake signals of one input buffer port.
interface phoenix_input_buffer_if #(
    parameter int unsigned TAM_FLIT = phoenix_input_buffer_pkg::TAM_FLIT
);
    logic                i_rx;
    logic [TAM_FLIT-1:0] i_data;
    logic                o_credit;
    logic                o_h;
    logic                i_ack_h;
    logic [TAM_FLIT-1:0] o_data;
    logic                o_data_av;
    logic                i_data_ack;
    logic                o_sender;

    // Environment side: link sender plus switchcontrol/crossbar
    modport master (
        output i_rx, i_data, i_ack_h, i_data_ack,
        input  o_credit, o_h, o_data, o_data_av, o_sender
    );

    // Input buffer side
    modport slave (
        input  i_rx, i_data, i_ack_h, i_data_ack,
        output o_credit, o_h, o_data, o_data_av, o_sender
    );
endinterface

// File: rtl/phoenix_flit_fifo.sv
// Circular flit FIFO; a push while full is accepted only when a pop frees a slot in the same cycle.
module phoenix_flit_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data_c,
    output logic             o_full_c,
    output logic             o_empty_c
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] first_q, first_d;
    logic [PTR_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Pointer and occupancy update; pointers wrap on their natural width
    always_comb begin
        first_d   = first_q;
        last_d    = last_q;
        count_d   = count_q;
        o_full_c  = (count_q == CNT_W'(DEPTH));
        o_empty_c = (count_q == '0);
        pop_ok    = i_pop & ~o_empty_c;
        push_ok   = i_push & (~o_full_c | pop_ok);
        if (pop_ok)  first_d = first_q + PTR_W'(1);
        if (push_ok) last_d  = last_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            first_q <= '0;
            last_q  <= '0;
            count_q <= '0;
        end else begin
            first_q <= first_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: only slots behind the write pointer are ever read
    always_ff @(posedge i_clk) begin
        if (push_ok) mem[last_q] <= i_data;
    end

    assign o_data_c = mem[first_q];

endmodule

// File: rtl/phoenix_input_buffer.sv
// Router input port: buffers link flits, requests a route per packet header and streams the packet after grant.
module phoenix_input_buffer
    import phoenix_input_buffer_pkg::*;
#(
    parameter int unsigned TAM_FLIT     = phoenix_input_buffer_pkg::TAM_FLIT,
    parameter int unsigned BUFFER_DEPTH = TAM_BUFFER
) (
    input logic                   i_clk,
    input logic                   i_rst,
    phoenix_input_buffer_if.slave bus
);
    ib_state_e           state_q, state_d;
    logic [TAM_FLIT-1:0] counter_q, counter_d;
    logic                sender_q, sender_d;

    logic [TAM_FLIT-1:0] fifo_data_c;
    logic                fifo_full_c;
    logic                fifo_empty_c;
    logic                h_c;
    logic                data_av_c;
    logic                pop_c;

    phoenix_flit_fifo #(
        .WIDTH (TAM_FLIT),
        .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_push    (bus.i_rx),
        .i_pop     (pop_c),
        .i_data    (bus.i_data),
        .o_data_c  (fifo_data_c),
        .o_full_c  (fifo_full_c),
        .o_empty_c (fifo_empty_c)
    );

    // Packet sequencing: request, header, size, payload countdown, one-cycle tail gap
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        sender_d  = sender_q;
        h_c       = (state_q == S_HEADER);
        data_av_c = 1'b0;
        case (state_q)
            S_SENDHEADER, S_SIZE, S_PAYLOAD: data_av_c = ~fifo_empty_c;
            default:                         data_av_c = 1'b0;
        endcase
        pop_c = data_av_c & bus.i_data_ack;

        case (state_q)
            S_INIT: begin
                if (!fifo_empty_c) state_d = S_HEADER;
            end
            S_HEADER: begin
                if (bus.i_ack_h) begin
                    state_d  = S_SENDHEADER;
                    sender_d = 1'b1;
                end
            end
            S_SENDHEADER: begin
                if (pop_c) state_d = S_SIZE;
            end
            S_SIZE: begin
                if (pop_c) begin
                    counter_d = fifo_data_c;
                    state_d   = (fifo_data_c == '0) ? S_END : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (pop_c) begin
                    counter_d = counter_q - TAM_FLIT'(1);
                    if (counter_q == TAM_FLIT'(1)) state_d = S_END;
                end
            end
            S_END: begin
                // Falling o_sender tells switchcontrol to release the output port
                sender_d = 1'b0;
                state_d  = S_INIT;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q   <= S_INIT;
            counter_q <= '0;
            sender_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            sender_q  <= sender_d;
        end
    end

    assign bus.o_credit  = ~fifo_full_c;
    assign bus.o_h       = h_c;
    assign bus.o_data    = fifo_data_c;
    assign bus.o_data_av = data_av_c;
    assign bus.o_sender  = sender_q;

endmodule
